// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out transmitter with valid/ready load and framing strobes
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic           sout_n, fs_n, accept;

    // A new word may be taken on the last-bit cycle so frames run back to back.
    assign load_ready   = !rst && (state == IDLE || (state == SHIFT && cnt == '0));
    assign accept       = load_valid && load_ready;
    assign serial_valid = state == SHIFT;
    assign busy         = serial_valid;
    assign done         = serial_valid && cnt == '0;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        sout_n  = serial_out;
        fs_n    = 1'b0;
        if (accept) begin
            state_n = SHIFT;
            cnt_n   = CW'(WIDTH - 1);
            sr_n    = MSB_FIRST ? parallel_in << 1 : parallel_in >> 1;
            sout_n  = MSB_FIRST ? parallel_in[WIDTH-1] : parallel_in[0];
            fs_n    = 1'b1;
        end else if (state == SHIFT && cnt != '0) begin
            cnt_n  = cnt - CW'(1);
            sr_n   = MSB_FIRST ? sr << 1 : sr >> 1;
            sout_n = MSB_FIRST ? sr[WIDTH-1] : sr[0];
        end else if (state == SHIFT) begin
            state_n = IDLE;
            sout_n  = IDLE_LEVEL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sr          <= '0;
            serial_out  <= IDLE_LEVEL;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sr          <= sr_n;
            serial_out  <= sout_n;
            frame_start <= fs_n;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of the serializer in MSB-first, LSB-first and 4-bit builds
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] m_pin = '0, l_pin = '0;
    logic [3:0] w_pin = '0;
    logic m_lv = 1'b0, l_lv = 1'b0, w_lv = 1'b0;
    logic m_lr, m_so, m_sv, m_fs, m_dn, m_bz;
    logic l_lr, l_so, l_sv, l_fs, l_dn, l_bz;
    logic w_lr, w_so, w_sv, w_fs, w_dn, w_bz;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .parallel_in(m_pin), .load_valid(m_lv), .load_ready(m_lr),
        .serial_out(m_so), .serial_valid(m_sv), .frame_start(m_fs), .done(m_dn), .busy(m_bz));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst(rst), .parallel_in(l_pin), .load_valid(l_lv), .load_ready(l_lr),
        .serial_out(l_so), .serial_valid(l_sv), .frame_start(l_fs), .done(l_dn), .busy(l_bz));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_w (
        .clk(clk), .rst(rst), .parallel_in(w_pin), .load_valid(w_lv), .load_ready(w_lr),
        .serial_out(w_so), .serial_valid(w_sv), .frame_start(w_fs), .done(w_dn), .busy(w_bz));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_m(input string tag, input logic so, input logic sv, input logic fs, input logic dn);
        chk({tag, " serial_out"}, {7'd0, m_so}, {7'd0, so});
        chk({tag, " serial_valid"}, {7'd0, m_sv}, {7'd0, sv});
        chk({tag, " busy"}, {7'd0, m_bz}, {7'd0, sv});
        chk({tag, " frame_start"}, {7'd0, m_fs}, {7'd0, fs});
        chk({tag, " done"}, {7'd0, m_dn}, {7'd0, dn});
    endtask

    initial begin
        logic [7:0] w;
        // reset held two cycles with load_valid asserted
        m_lv = 1'b1; m_pin = 8'hFF;
        tick();
        chk_m("rst1", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst1 load_ready", {7'd0, m_lr}, 8'd0);
        tick();
        chk_m("rst2", 1'b0, 1'b0, 1'b0, 1'b0);
        m_lv = 1'b0;
        rst = 1'b0;
        #1;
        chk("post-rst load_ready", {7'd0, m_lr}, 8'd1);
        tick();
        chk_m("post-rst idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // single MSB-first frame
        w = 8'b1011_0011;
        m_pin = w; m_lv = 1'b1;
        tick();
        m_lv = 1'b0; m_pin = 'x;
        for (int k = 0; k < 8; k++) begin
            chk_m($sformatf("single b%0d", k), w[7-k], 1'b1, k == 0, k == 7);
            tick();
        end
        chk_m("single idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // back-to-back frames with load_valid held throughout
        m_pin = 8'hA5; m_lv = 1'b1;
        tick();
        for (int c = 0; c < 16; c++) begin
            w = c < 8 ? 8'hA5 : 8'h3C;
            chk_m($sformatf("b2b c%0d", c + 1), w[7-(c%8)], 1'b1, c % 8 == 0, c % 8 == 7);
            chk($sformatf("b2b c%0d load_ready", c + 1), {7'd0, m_lr}, {7'd0, c % 8 == 7});
            if (c == 7) m_pin = 8'h3C;
            if (c == 15) m_lv = 1'b0;
            tick();
        end
        chk_m("b2b idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // a mid-frame load pulse must be ignored
        m_pin = 8'h00; m_lv = 1'b1;
        tick();
        m_lv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_m($sformatf("ign b%0d", k), 1'b0, 1'b1, k == 0, k == 7);
            if (k == 2) begin
                m_lv = 1'b1; m_pin = 8'hFF;
                #1;
                chk("ign load_ready", {7'd0, m_lr}, 8'd0);
            end
            tick();
            m_lv = 1'b0;
        end
        chk_m("ign idle", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_m("ign no 2nd frame", 1'b0, 1'b0, 1'b0, 1'b0);

        // reset aborts a frame at bit 4
        m_pin = 8'hF0; m_lv = 1'b1;
        tick();
        m_lv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_m($sformatf("abort b%0d", k), 1'b1, 1'b1, k == 0, 1'b0);
            if (k == 3) rst = 1'b1;
            tick();
        end
        chk_m("abort idle", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        w = 8'h81;
        m_pin = w; m_lv = 1'b1;
        tick();
        m_lv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_m($sformatf("after-abort b%0d", k), w[7-k], 1'b1, k == 0, k == 7);
            tick();
        end
        chk_m("after-abort idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // LSB-first build
        l_pin = 8'b1011_0011; l_lv = 1'b1;
        tick();
        l_lv = 1'b0; l_pin = 'x;
        for (int k = 0; k < 8; k++) begin
            w = 8'b1011_0011;
            chk($sformatf("lsb b%0d serial_out", k), {7'd0, l_so}, {7'd0, w[k]});
            chk($sformatf("lsb b%0d serial_valid", k), {7'd0, l_sv}, 8'd1);
            chk($sformatf("lsb b%0d done", k), {7'd0, l_dn}, {7'd0, k == 7});
            tick();
        end
        chk("lsb idle serial_valid", {7'd0, l_sv}, 8'd0);
        chk("lsb idle serial_out", {7'd0, l_so}, 8'd0);

        // 4-bit build
        w_pin = 4'b1001; w_lv = 1'b1;
        tick();
        w_lv = 1'b0; w_pin = 'x;
        for (int k = 0; k < 4; k++) begin
            w = 8'b0000_1001;
            chk($sformatf("w4 b%0d serial_out", k), {7'd0, w_so}, {7'd0, w[3-k]});
            chk($sformatf("w4 b%0d frame_start", k), {7'd0, w_fs}, {7'd0, k == 0});
            chk($sformatf("w4 b%0d done", k), {7'd0, w_dn}, {7'd0, k == 3});
            tick();
        end
        chk("w4 idle serial_valid", {7'd0, w_sv}, 8'd0);
        chk("w4 idle busy", {7'd0, w_bz}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
